// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// It receives a length-prefixed byte stream and assembles big-endian 32-bit words.
// Each word is written to instruction memory from word index 0 upward.
// The CPU is held in reset until the trailing XOR checksum has been verified.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  // Largest legal image, in words. One bit wider than the length field so that
  // a 16-bit address space can still be described.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR
  } state_t;

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [23:0] wbuf;
  logic [1:0]  byte_cnt;

  logic        accept;
  logic [15:0] len_n;

  assign accept = in_valid && in_ready;
  assign len_n  = {len_hi, in_data};

  // Load FSM with registered handshake, status and memory-write outputs.
  // words_loaded doubles as the word index, because it always equals the next address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      len_hi       <= '0;
      len          <= '0;
      csum         <= '0;
      wbuf         <= '0;
      byte_cnt     <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN_HI;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
            byte_cnt     <= '0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_hi <= in_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len <= len_n;
            if (len_n == 16'd0 || {1'b0, len_n} > DEPTH) begin
              state    <= ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum     <= csum ^ in_data;
            wbuf     <= {wbuf[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            // ---- write stage: the completed word is presented to memory next cycle ----
            if (byte_cnt == 2'd3) begin
              im_we        <= 1'b1;
              im_addr      <= words_loaded[ADDR_W-1:0];
              im_wdata     <= {wbuf, in_data};
              words_loaded <= words_loaded + 16'd1;
              if (words_loaded + 16'd1 == len) begin
                state <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader that sits directly upstream of the single-cycle MIPS CPU. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written into instruction memory starting at word index 0, which corresponds to TEXT_BASE 0x0000_3000. The loader holds the CPU in reset until a complete image has been received and its checksum verified, so the CPU never executes a partially loaded program.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width; DEPTH = 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader can accept a byte.
- im_we  out  1  instruction-memory write enable.
- im_addr  out  ADDR_W  instruction-memory word address.
- im_wdata  out  32  instruction-memory write data.
- cpu_rst  out  1  active-high reset to the CPU.
- busy  out  1  load in progress.
- done  out  1  image loaded and verified.
- err  out  1  load failed.
- words_loaded  out  16  number of words written in the current or last load.

## Operation
- **Stream format**
  - Two length bytes N, MSB first.
  - Then 4N data bytes. Each word is sent MSB first.
  - Then one checksum byte, equal to the XOR of all 4N data bytes. The length bytes are excluded.
- **Byte acceptance:** a byte is accepted on a rising edge where in_valid && in_ready.
- **States:** IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- **IDLE / DONE / ERR + start**
  - Go to LEN_HI.
  - Set cpu_rst=1; clear done, err, words_loaded, the checksum accumulator and the byte counter.
- **start in any other state:** ignored.
- **LEN_HI:** on accept, latch the high length byte and go to LEN_LO.
- **LEN_LO:** on accept, form N.
  - N==0 or N>DEPTH → ERR.
  - Otherwise → DATA.
- **DATA**
  - On each accept, shift the byte into the word buffer and XOR it into the checksum.
  - On the 4th byte of a word, im_we is registered high for exactly the next cycle, with im_addr = word index and im_wdata = the assembled word. words_loaded increments in that same cycle.
  - After the 4th byte of word N-1, go to CSUM.
- **CSUM:** on accept, compare the byte with the accumulator.
  - Match → DONE.
  - Mismatch → ERR.
- **DONE:** cpu_rst=0, done=1, in_ready=0.
- **ERR**
  - cpu_rst stays 1, err=1, in_ready=0.
  - Words already written are not rolled back.
- **in_ready:** 1 exactly in LEN_HI, LEN_LO, DATA and CSUM. The memory write never stalls the input stream.
- **busy:** 1 in LEN_HI through CSUM.
- **im_addr / im_wdata:** hold their last values when im_we=0.
- **Arithmetic:** word index is ADDR_W bits. It never wraps, because N≤DEPTH is enforced before DATA.

## Timing
- **Reset values:** state IDLE, cpu_rst=1, in_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0, words_loaded=0.
- **Reset is asynchronous:** asserting rst low forces all outputs to their reset values immediately, including mid-load. Released CPU reset is re-asserted at once.
- **Start latency:** start sampled in cycle t → in_ready=1 and busy=1 from cycle t+1.
- **Write latency:** 4th byte of a word accepted at edge t → im_we high during cycle t+1 only.
  - Back-to-back bytes yield at most one im_we every 4 cycles.
- **Last-word write:** the write for the last word completes no later than the cycle in which the checksum byte can first be accepted.
- **Checksum latency:** checksum byte accepted at edge t → done=1 (or err=1) and cpu_rst=0 (DONE only) from cycle t+1. The CPU sees its first clock out of reset at edge t+2.
- **Length error:** the length error is flagged in the cycle after the LEN_LO accept; no im_we is ever issued in that case.
- **Gaps:** in_valid low cycles between bytes do not affect the result.
- **Restart:** start in DONE re-asserts cpu_rst in the cycle after start is sampled.

## Test plan
1. **Good load:** start, then stream 00 03, 20 10 00 01, 20 11 00 02, 02 11 90 20, A1 back-to-back.
   - Expect im_we pulses at addr 0, 1, 2 with data 0x20100001, 0x20110002, 0x02119020.
   - Expect done=1 and cpu_rst=0 one cycle after the checksum accept, words_loaded=3, err=0.
2. **Bad checksum:** same stream with checksum byte A0.
   - Expect three writes, then err=1, cpu_rst=1, done=0, in_ready=0.
3. **Length limits:** with ADDR_W=10, send length 00 00, and in a separate load send 04 01.
   - Expect err=1 one cycle after the LEN_LO accept, no im_we, in_ready=0.
   - Length 04 00 with 4096 data bytes and the correct checksum → done=1; the last write is at addr 0x3FF.
4. **Throttled input:** repeat scenario 1 with random 0–5 cycle in_valid gaps.
   - Expect identical write sequence and final state.
   - in_data toggled while in_valid=0 has no effect.
5. **Reset mid-load:** pull rst low asynchronously after the 5th byte of scenario 1.
   - Expect all outputs at reset values before the next edge.
   - After release, start plus the full scenario 1 stream → done=1, words_loaded=3.
6. **Start handling:** pulse start during DATA → ignored, the load completes normally. Pulse start in DONE → cpu_rst=1, busy=1 next cycle, done cleared; a second load of 00 01, 00 00 00 00, 00 → done=1.
